// File: rtl/display_pkg.sv
// Shared definitions for the BCD display stage: segment patterns, FSM states
// and a helper that sizes the digit count for a given binary width.
package display_pkg;

    // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int min_digits(input int width);
        longint unsigned max_val;
        longint unsigned lim;
        int              d;
        max_val = (longint'(1) << width) - 1;
        lim     = 10;
        d       = 1;
        while (lim <= max_val) begin
            d   = d + 1;
            lim = lim * 10;
        end
        return d;
    endfunction

endpackage

// File: rtl/count_bcd_display_bcd_to_seg7.sv
// Combinational 4-bit BCD to active-low seven-segment decoder.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/count_bcd_display.sv
// Sequential binary-to-BCD (double-dabble, one bit per clock) converter that
// drives active-low seven-segment patterns and holds the last result.
module count_bcd_display
    import display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_bitcnt;
    logic [WIDTH-1:0]      r_shift;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [7*DIGITS-1:0]   r_hex;
    logic [7*DIGITS-1:0]   w_seg;
    logic                  r_done;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_bitcnt == CNT_W'(1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = r_done;
        bcd  = r_bcd;
        hex  = r_hex;
    end

    // Add-3 correction on every digit before the shift, all digits in parallel
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_hex     <= {DIGITS{SEG_0}};
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_bitcnt  <= CNT_W'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    {r_scratch, r_shift} <= {w_adj[4*DIGITS-2:0], r_shift, 1'b0};
                    r_bitcnt             <= r_bitcnt - CNT_W'(1);
                end
                S_DONE: begin
                    r_bcd <= r_scratch;
                    r_hex <= w_seg;
                end
                default: ;
            endcase
        end
    end

    // Decoders see the registered scratch digits; outputs capture them in DONE
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .i_bcd (r_scratch[4*g +: 4]),
            .o_seg (w_seg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed plus randomized bench for count_bcd_display against a decimal-arithmetic reference.
module tb_count_bcd_display;

    logic        clk;
    logic        clr;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [20:0] hex;

    int total;
    int bad;

    localparam logic [6:0] SEG_TAB [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [20:0] HEX_RST = {3{7'b1000000}};

    count_bcd_display #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .hex   (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [20:0] ref_hex(input int v);
        logic [20:0] h;
        int          x;
        x = v;
        for (int d = 0; d < 3; d++) begin
            h[7*d +: 7] = SEG_TAB[x % 10];
            x = x / 10;
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one request and wait (bounded) for the done pulse
    task automatic conv(input logic [7:0] v, output int lat, output int bcnt, output logic dn);
        bin   = v;
        start = 1'b1;
        lat   = -1;
        bcnt  = 0;
        dn    = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = n - 1;
                dn  = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          bcnt;
        logic        dn;
        int          ndone;
        logic [11:0] cap;
        int          cyc;
        int          first_cyc;
        int          second_cyc;
        logic [11:0] res1;
        logic [11:0] res2;
        int          v;
        logic        dig_ok;

        total = 0;
        bad   = 0;
        clr   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd),  32'h000);
        chk("rst_hex",  32'(hex),  32'(HEX_RST));
        clr = 1'b0;
        step();

        conv(8'd0, lat, bcnt, dn);
        chk("zero_done", 32'(dn), 32'd1);
        chk("zero_lat",  32'(lat), 32'd9);
        chk("zero_bcd",  32'(bcd), 32'h000);
        chk("zero_hex",  32'(hex), 32'(HEX_RST));
        step();
        chk("zero_done_width", 32'(done), 32'd0);

        conv(8'hFF, lat, bcnt, dn);
        chk("ff_done", 32'(dn), 32'd1);
        chk("ff_bcd",  32'(bcd), 32'h255);
        chk("ff_hex",  32'(hex), 32'({7'b0100100, 7'b0010010, 7'b0010010}));
        chk("ff_busy_cycles", 32'(bcnt), 32'd9);
        chk("ff_busy_in_done", 32'(busy), 32'd0);
        step();

        // Capture 128, then disturb bin and pulse start during SHIFT
        bin   = 8'd128;
        start = 1'b1;
        step();
        bin   = 8'd7;
        start = 1'b0;
        chk("hold_bcd", 32'(bcd), 32'h255);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        cap   = '0;
        for (int n = 0; n < 25; n++) begin
            if (done) begin
                ndone++;
                cap = bcd;
            end
            step();
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_bcd", 32'(cap), 32'h128);

        // start held high: back-to-back conversions
        bin        = 8'd99;
        start      = 1'b1;
        cyc        = 0;
        first_cyc  = -1;
        second_cyc = -1;
        res1       = '0;
        res2       = '0;
        for (int n = 0; n < 40; n++) begin
            step();
            cyc++;
            if (done) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    res1      = bcd;
                    bin       = 8'd100;
                end else begin
                    second_cyc = cyc;
                    res2       = bcd;
                    start      = 1'b0;
                    break;
                end
            end
        end
        chk("b2b_first_lat", 32'(first_cyc), 32'd10);
        chk("b2b_gap", 32'(second_cyc - first_cyc), 32'd10);
        chk("b2b_res1", 32'(res1), 32'h099);
        chk("b2b_res2", 32'(res2), 32'h100);
        chk("b2b_hex2", 32'(hex), 32'(ref_hex(100)));
        repeat (3) step();

        // Abort a conversion of 200 at shift 4
        bin   = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        @(posedge clk);
        #1 clr = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd",  32'(bcd),  32'h000);
        chk("abort_hex",  32'(hex),  32'(HEX_RST));
        @(negedge clk);
        clr   = 1'b0;
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            step();
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_bcd_hold", 32'(bcd), 32'h000);
        conv(8'd200, lat, bcnt, dn);
        chk("post_abort_done", 32'(dn), 32'd1);
        chk("post_abort_bcd", 32'(bcd), 32'h200);
        chk("post_abort_hex", 32'(hex), 32'(ref_hex(200)));
        step();

        // Random values with random idle gaps
        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) step();
            conv(8'(v), lat, bcnt, dn);
            chk($sformatf("rnd_done_%0d", v), 32'(dn), 32'd1);
            chk($sformatf("rnd_lat_%0d", v), 32'(lat), 32'd9);
            chk($sformatf("rnd_bcd_%0d", v), 32'(bcd), 32'(ref_bcd(v)));
            chk($sformatf("rnd_hex_%0d", v), 32'(hex), 32'(ref_hex(v)));
        end

        // Counter sweep 0..255, one request per increment
        for (int c = 0; c < 256; c++) begin
            conv(8'(c), lat, bcnt, dn);
            dig_ok = (bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[11:8] <= 4'd9);
            chk($sformatf("sweep_done_%0d", c), 32'(dn), 32'd1);
            chk($sformatf("sweep_bcd_%0d", c), 32'(bcd), 32'(ref_bcd(c)));
            chk($sformatf("sweep_digits_%0d", c), 32'(dig_ok), 32'd1);
            chk($sformatf("sweep_hex_%0d", c), 32'(hex), 32'(ref_hex(c)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_bcd_display.md
# count_bcd_display

Sequential binary-to-decimal display stage that sits directly downstream of the cascaded T-flip-flop counter. It samples the counter's WIDTH-bit `count` on request and converts it to packed BCD with a shift-and-add-3 (double-dabble) datapath, one bit per clock. It drives active-low seven-segment patterns for the board HEX displays, and holds the last result between conversions.

## Interface
- `WIDTH`, 8, binary input width; matches the counter width.
- `DIGITS`, 3, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH − 1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `clr`  in  1  reset, asynchronous, active-high; forces all state and outputs to reset values immediately.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin`  in  WIDTH  binary value (counter `count`); captured on the edge that accepts `start`.
- `busy`  out  1  high while a conversion is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when `bcd`/`hex` have just updated.
- `bcd`  out  4·DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
- `hex`  out  7·DIGITS  segment patterns, 7 bits per digit, digit 0 in [6:0]; bit 0 = segment a … bit 6 = segment g; active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if `start`=1 then load shift register ← `bin`, scratch BCD ← 0, bit counter ← WIDTH, go SHIFT. Otherwise hold.
- SHIFT (one bit per cycle):
  - Every scratch digit ≥ 5 gets +3 (all digits adjusted in parallel).
  - Then {scratch, shift register} shifts left by 1, and the bit counter decrements.
  - When the counter reaches 0, go DONE.
- DONE:
  - `bcd` ← scratch.
  - `hex` ← decoded scratch.
  - `done` ← 1 for one cycle.
  - Go IDLE.
- `start` in SHIFT or DONE is ignored: no queuing and no restart. `bin` changes after capture have no effect.
- Outputs `bcd`/`hex` change only on the DONE edge; they hold otherwise.
- Decoder covers digits 0–9. Codes 10–15 cannot occur; they map to all segments off (7'h7F).
- No leading-zero blanking: every digit always shows.

## Timing
- Let edge k be the edge that samples `start`=1 in IDLE.
  - Shifts occur on edges k+1 … k+WIDTH.
  - DONE updates happen on edge k+WIDTH+1.
  - `done` is high for exactly the cycle following edge k+WIDTH+1.
  - For WIDTH=8: 9 edges from acceptance to results.
- `busy` is high in the cycles following edges k … k+WIDTH. It is low in the `done` cycle.
- A `start` held high during the `done` cycle is accepted. Maximum throughput is one conversion per WIDTH+2 cycles.
- Reset values:
  - state IDLE.
  - `busy`=0, `done`=0.
  - `bcd`=0.
  - `hex` = every digit showing "0" (7'b1000000 per digit).
  - Internal registers all 0.
- `clr` asserted mid-conversion: the conversion is aborted with no `done` pulse, and outputs return to reset values. The first `start` after `clr` deasserts is accepted normally.

## Structure
- Shared package `display_pkg`:
  - seven-segment constants (SEG_0 … SEG_9, SEG_OFF);
  - FSM state enum;
  - helper function computing the minimum DIGITS for a WIDTH.
- Sub-module `bcd_to_seg7`: combinational 4-bit BCD → 7-bit active-low decoder, instantiated DIGITS times in a generate loop on the registered scratch digits.
- Top holds the FSM, bit counter ($clog2(WIDTH+1) bits), shift register, scratch BCD and output registers.

## Test plan
- Reset, then `start` with `bin`=0 → after 9 edges `done`=1, `bcd`=12'h000, `hex` = three × 7'b1000000.
- `bin`=255 (8'hFF) → `bcd`=12'h255, `hex` digit2/1/0 = 7'b0100100 / 7'b0010010 / 7'b0010010; `busy` high exactly 9 cycles before `done`.
- `bin`=128, then `bin` changed to 7 on the next cycle and `start` pulsed again during SHIFT → single result `bcd`=12'h128; second `start` ignored; only one `done` pulse.
- `start` held high continuously with `bin`=99 then 100 → back-to-back conversions every 10 cycles, results 12'h099 then 12'h100; `start` in the `done` cycle accepted.
- Assert `clr` at shift 4 of a conversion of 200 → outputs immediately at reset values and no `done`. After release, a new `start` with `bin`=200 gives `bcd`=12'h200.
- Sweep: counter driven 0→255 with `start` after each increment → every `bcd` equals the decimal of `bin`, and every digit is ≤ 9.
